uart_cmd_sequencer: RTL and testbench

UART_CMD_SEQUENCER -- requirements
Module: uart_cmd_sequencer

---
 rtl/uart_cmd_pkg.sv | 27 ++
 rtl/uart_cmd_if.sv | 24 ++
 rtl/cmd_timeout_timer.sv | 31 +++
 rtl/uart_cmd_sequencer.sv | 146 ++++++++++++++
 tb/tb_uart_cmd_sequencer.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command sequencer: FSM state encoding,
// default frame marker, frame byte layout and the frame checksum.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_ADDR = 3'd1,
    ST_GET_DATA = 3'd2,
    ST_GET_CHK  = 3'd3,
    ST_WRITE    = 3'd4
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  localparam int unsigned FRAME_LEN      = 4;
  localparam int unsigned FRAME_POS_SYNC = 0;
  localparam int unsigned FRAME_POS_ADDR = 1;
  localparam int unsigned FRAME_POS_DATA = 2;
  localparam int unsigned FRAME_POS_CHK  = 3;

  function automatic logic [7:0] frame_chk(input logic [7:0] sync,
                                           input logic [7:0] addr,
                                           input logic [7:0] data);
    return sync ^ addr ^ data;
  endfunction

endpackage

// File: rtl/uart_cmd_if.sv
// Byte stream from the UART receiver, register-bank write port and status
// counters of the command sequencer.
interface uart_cmd_if;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       RX_PERR;
  logic [1:0] REG_ADDR;
  logic [7:0] REG_WDATA;
  logic       REG_WE;
  logic       REG_ACK;
  logic       BUSY;
  logic [7:0] CMD_COUNT;
  logic [7:0] ERR_COUNT;

  modport master (
    input  RX_DATA, RX_VALID, RX_PERR, REG_ACK,
    output REG_ADDR, REG_WDATA, REG_WE, BUSY, CMD_COUNT, ERR_COUNT
  );

  modport slave (
    output RX_DATA, RX_VALID, RX_PERR, REG_ACK,
    input  REG_ADDR, REG_WDATA, REG_WE, BUSY, CMD_COUNT, ERR_COUNT
  );
endinterface

// File: rtl/cmd_timeout_timer.sv
// Inter-byte timeout: down-counter reloaded by clear, expired is raised on the
// TIMEOUT_CYCLES-th enabled cycle after the last clear.
module cmd_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input  logic CLK50MHz,
  input  logic RESET,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LOAD = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK50MHz) begin
    if (RESET) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= LOAD;
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  // Only meaningful while enabled; the FSM always clears on the byte that enters a GET state.
  assign expired = enable && (cnt == '0);

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Receives SYNC/ADDR/DATA/CHK frames from a UART and turns each valid frame
// into one acknowledged register write, counting completed and rejected frames.
//
// state       | meaning
// ST_IDLE     | hunting for SYNC_BYTE, other bytes silently dropped
// ST_GET_ADDR | waiting for the address byte
// ST_GET_DATA | waiting for the data byte
// ST_GET_CHK  | waiting for the checksum byte
// ST_WRITE    | REG_WE held until REG_ACK, no timeout
module uart_cmd_sequencer
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 500000,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
  input  logic       CLK50MHz,
  input  logic       RESET,
  uart_cmd_if.master bus
);

  state_t     state;
  logic [1:0] addr_q;
  logic [7:0] data_q;
  logic       in_get;
  logic       timer_expired;
  logic       addr_bad;
  logic       chk_ok;
  logic       err_event;

  assign in_get   = (state == ST_GET_ADDR) || (state == ST_GET_DATA) || (state == ST_GET_CHK);
  assign addr_bad = (bus.RX_DATA[7:2] != 6'd0);
  assign chk_ok   = (bus.RX_DATA == frame_chk(SYNC_BYTE, {6'd0, addr_q}, data_q));

  cmd_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .CLK50MHz(CLK50MHz),
    .RESET   (RESET),
    .clear   (bus.RX_VALID),
    .enable  (in_get),
    .expired (timer_expired)
  );

  // A strobed byte always wins over a coincident timeout; any number of
  // simultaneous error causes collapse into a single count.
  always_comb begin
    err_event = 1'b0;
    case (state)
      ST_GET_ADDR: err_event = bus.RX_VALID ? (bus.RX_PERR || addr_bad) : timer_expired;
      ST_GET_DATA: err_event = bus.RX_VALID ? bus.RX_PERR : timer_expired;
      ST_GET_CHK:  err_event = bus.RX_VALID ? (bus.RX_PERR || !chk_ok) : timer_expired;
      ST_WRITE:    err_event = bus.RX_VALID;
      default:     err_event = 1'b0;
    endcase
  end

  always_ff @(posedge CLK50MHz) begin
    if (RESET) begin
      state         <= ST_IDLE;
      addr_q        <= '0;
      data_q        <= '0;
      bus.REG_ADDR  <= '0;
      bus.REG_WDATA <= '0;
      bus.REG_WE    <= 1'b0;
      bus.BUSY      <= 1'b0;
      bus.CMD_COUNT <= '0;
      bus.ERR_COUNT <= '0;
    end else begin
      if (err_event && (bus.ERR_COUNT != 8'hFF)) begin
        bus.ERR_COUNT <= bus.ERR_COUNT + 8'd1;
      end

      case (state)
        ST_IDLE: begin
          if (bus.RX_VALID && !bus.RX_PERR && (bus.RX_DATA == SYNC_BYTE)) begin
            state    <= ST_GET_ADDR;
            bus.BUSY <= 1'b1;
          end
        end

        ST_GET_ADDR: begin
          if (bus.RX_VALID) begin
            if (!bus.RX_PERR && !addr_bad) begin
              addr_q <= bus.RX_DATA[1:0];
              state  <= ST_GET_DATA;
            end else begin
              state    <= ST_IDLE;
              bus.BUSY <= 1'b0;
            end
          end else if (timer_expired) begin
            state    <= ST_IDLE;
            bus.BUSY <= 1'b0;
          end
        end

        ST_GET_DATA: begin
          if (bus.RX_VALID) begin
            if (!bus.RX_PERR) begin
              data_q <= bus.RX_DATA;
              state  <= ST_GET_CHK;
            end else begin
              state    <= ST_IDLE;
              bus.BUSY <= 1'b0;
            end
          end else if (timer_expired) begin
            state    <= ST_IDLE;
            bus.BUSY <= 1'b0;
          end
        end

        ST_GET_CHK: begin
          if (bus.RX_VALID) begin
            if (!bus.RX_PERR && chk_ok) begin
              bus.REG_ADDR  <= addr_q;
              bus.REG_WDATA <= data_q;
              bus.REG_WE    <= 1'b1;
              state         <= ST_WRITE;
            end else begin
              state    <= ST_IDLE;
              bus.BUSY <= 1'b0;
            end
          end else if (timer_expired) begin
            state    <= ST_IDLE;
            bus.BUSY <= 1'b0;
          end
        end

        ST_WRITE: begin
          if (bus.REG_ACK) begin
            bus.REG_WE    <= 1'b0;
            bus.BUSY      <= 1'b0;
            bus.CMD_COUNT <= bus.CMD_COUNT + 8'd1;
            state         <= ST_IDLE;
          end
        end

        default: begin
          state      <= ST_IDLE;
          bus.BUSY   <= 1'b0;
          bus.REG_WE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Directed bench for uart_cmd_sequencer; expected register writes are queued
// as frames are sent and checked by a monitor when REG_WE rises.
module tb_uart_cmd_sequencer;
  import uart_cmd_pkg::*;

  localparam int unsigned TMO  = 100;
  localparam logic [7:0]  SYNC = 8'hA5;

  typedef struct packed {
    logic [1:0] addr;
    logic [7:0] data;
  } wr_t;

  logic CLK50MHz;
  logic RESET;
  int   n_chk  = 0;
  int   n_fail = 0;
  wr_t  exp_q[$];
  wr_t  cur_exp;
  logic we_prev = 1'b0;

  uart_cmd_if bus();

  uart_cmd_sequencer #(
    .TIMEOUT_CYCLES(TMO),
    .SYNC_BYTE     (SYNC)
  ) dut (
    .CLK50MHz(CLK50MHz),
    .RESET   (RESET),
    .bus     (bus)
  );

  initial CLK50MHz = 1'b0;
  always #10 CLK50MHz = ~CLK50MHz;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK50MHz);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic perr);
    bus.RX_DATA  = b;
    bus.RX_VALID = 1'b1;
    bus.RX_PERR  = perr;
    tick();
    bus.RX_VALID = 1'b0;
    bus.RX_PERR  = 1'b0;
    bus.RX_DATA  = 8'h00;
  endtask

  // corrupt flips the checksum LSB; a good frame with a legal address is queued.
  task automatic send_frame(input logic [7:0] addr, input logic [7:0] data, input logic corrupt);
    logic [7:0] fr [FRAME_LEN];
    fr[FRAME_POS_SYNC] = SYNC;
    fr[FRAME_POS_ADDR] = addr;
    fr[FRAME_POS_DATA] = data;
    fr[FRAME_POS_CHK]  = SYNC ^ addr ^ data ^ {7'd0, corrupt};
    if (!corrupt && addr[7:2] == 6'd0) exp_q.push_back('{addr: addr[1:0], data: data});
    for (int k = 0; k < FRAME_LEN; k++) send_byte(fr[k], 1'b0);
  endtask

  task automatic ack_write(input int dly, output int hi);
    int guard;
    guard = 0;
    hi    = 0;
    while (bus.REG_WE !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    check("we_seen", bus.REG_WE, 1);
    if (bus.REG_WE === 1'b1) begin
      repeat (dly) begin
        if (bus.REG_WE === 1'b1) hi++;
        tick();
      end
      if (bus.REG_WE === 1'b1) hi++;
      bus.REG_ACK = 1'b1;
      tick();
      bus.REG_ACK = 1'b0;
    end
  endtask

  always @(negedge CLK50MHz) begin
    if (bus.REG_WE === 1'b1 && we_prev !== 1'b1) begin
      check("write_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        cur_exp = exp_q.pop_front();
        check("wr_addr", bus.REG_ADDR, cur_exp.addr);
        check("wr_data", bus.REG_WDATA, cur_exp.data);
      end
    end else if (bus.REG_WE === 1'b1) begin
      check("wr_addr_stable", bus.REG_ADDR, cur_exp.addr);
      check("wr_data_stable", bus.REG_WDATA, cur_exp.data);
    end
    we_prev = bus.REG_WE;
  end

  initial begin
    int hi;
    bus.RX_DATA  = 8'h00;
    bus.RX_VALID = 1'b0;
    bus.RX_PERR  = 1'b0;
    bus.REG_ACK  = 1'b0;
    RESET        = 1'b1;
    repeat (3) tick();
    send_byte(SYNC, 1'b0);
    check("rst_we", bus.REG_WE, 0);
    check("rst_busy", bus.BUSY, 0);
    check("rst_addr", bus.REG_ADDR, 0);
    check("rst_wdata", bus.REG_WDATA, 0);
    check("rst_cmd", bus.CMD_COUNT, 0);
    check("rst_err", bus.ERR_COUNT, 0);
    check("rst_timer", dut.u_timer.cnt, 0);
    RESET = 1'b0;
    tick();

    // Basic write, ack two cycles after REG_WE rises
    send_byte(8'hA5, 1'b0);
    check("busy_after_sync", bus.BUSY, 1);
    exp_q.push_back('{addr: 2'd1, data: 8'h3C});
    send_byte(8'h01, 1'b0);
    send_byte(8'h3C, 1'b0);
    send_byte(8'h98, 1'b0);
    check("we_after_chk", bus.REG_WE, 1);
    check("addr_1", bus.REG_ADDR, 1);
    check("wdata_3c", bus.REG_WDATA, 8'h3C);
    ack_write(2, hi);
    check("we_cycles", hi, 3);
    check("we_dropped", bus.REG_WE, 0);
    check("cmd_1", bus.CMD_COUNT, 1);
    check("busy_idle", bus.BUSY, 0);

    // Stray acknowledge
    bus.REG_ACK = 1'b1;
    repeat (3) tick();
    bus.REG_ACK = 1'b0;
    check("stray_ack_cmd", bus.CMD_COUNT, 1);
    check("stray_ack_we", bus.REG_WE, 0);

    // Bad checksum
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h3C, 1'b0);
    send_byte(8'h99, 1'b0);
    check("badchk_we", bus.REG_WE, 0);
    check("badchk_err", bus.ERR_COUNT, 1);
    check("badchk_busy", bus.BUSY, 0);

    // Bad address then a good frame to register 2
    send_byte(8'hA5, 1'b0);
    send_byte(8'h04, 1'b0);
    check("badaddr_err", bus.ERR_COUNT, 2);
    check("badaddr_busy", bus.BUSY, 0);
    exp_q.push_back('{addr: 2'd2, data: 8'h55});
    send_byte(8'hA5, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'hF2, 1'b0);
    check("reg2_addr", bus.REG_ADDR, 2);
    ack_write(0, hi);
    check("cmd_2", bus.CMD_COUNT, 2);

    // Idle noise is ignored, including a sync byte with parity error
    send_byte(8'h00, 1'b0);
    send_byte(8'h5A, 1'b0);
    send_byte(8'hA5, 1'b1);
    check("idle_noise_err", bus.ERR_COUNT, 2);
    check("idle_noise_busy", bus.BUSY, 0);

    // Parity errors in GET states; double error source counts once
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h3C, 1'b1);
    check("perr_data_err", bus.ERR_COUNT, 3);
    send_byte(8'hA5, 1'b0);
    send_byte(8'hFC, 1'b1);
    check("double_err", bus.ERR_COUNT, 4);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h3C, 1'b0);
    send_byte(8'h98, 1'b1);
    check("perr_chk_err", bus.ERR_COUNT, 5);
    check("perr_chk_we", bus.REG_WE, 0);

    // Byte on the timeout cycle wins
    send_byte(8'hA5, 1'b0);
    repeat (TMO - 1) tick();
    exp_q.push_back('{addr: 2'd1, data: 8'h3C});
    send_byte(8'h01, 1'b0);
    send_byte(8'h3C, 1'b0);
    send_byte(8'h98, 1'b0);
    check("tmo_edge_err", bus.ERR_COUNT, 5);
    ack_write(0, hi);
    check("cmd_3", bus.CMD_COUNT, 3);

    // Timeout in GET_ADDR and GET_CHK
    send_byte(8'hA5, 1'b0);
    repeat (TMO - 1) tick();
    check("tmo_pre_busy", bus.BUSY, 1);
    tick();
    check("tmo_busy", bus.BUSY, 0);
    check("tmo_err", bus.ERR_COUNT, 6);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h3C, 1'b0);
    repeat (TMO - 1) tick();
    check("tmo_chk_pre_err", bus.ERR_COUNT, 6);
    tick();
    check("tmo_chk_err", bus.ERR_COUNT, 7);
    check("tmo_chk_busy", bus.BUSY, 0);

    // Overrun during WRITE, no timeout while waiting for ack
    send_frame(8'h03, 8'hC3, 1'b0);
    check("ovr_we_before", bus.REG_WE, 1);
    send_byte(8'h11, 1'b0);
    check("ovr_err", bus.ERR_COUNT, 8);
    check("ovr_we", bus.REG_WE, 1);
    send_byte(8'h22, 1'b1);
    check("ovr_perr_err", bus.ERR_COUNT, 9);
    repeat (TMO + 50) tick();
    check("write_no_tmo_err", bus.ERR_COUNT, 9);
    check("write_no_tmo_we", bus.REG_WE, 1);
    ack_write(1, hi);
    check("cmd_4", bus.CMD_COUNT, 4);

    // Reset during WRITE discards the pending write
    send_frame(8'h00, 8'h7E, 1'b0);
    check("pre_rst_we", bus.REG_WE, 1);
    RESET = 1'b1;
    tick();
    check("rst_write_we", bus.REG_WE, 0);
    check("rst_write_cmd", bus.CMD_COUNT, 0);
    check("rst_write_busy", bus.BUSY, 0);
    RESET = 1'b0;
    repeat (3) tick();
    check("rst_write_stays", bus.REG_WE, 0);

    // Reset mid-frame: tail bytes are ignored afterwards
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    send_byte(8'h3C, 1'b0);
    send_byte(8'h98, 1'b0);
    check("rst_frame_busy", bus.BUSY, 0);
    check("rst_frame_we", bus.REG_WE, 0);
    check("rst_frame_err", bus.ERR_COUNT, 0);

    // Error counter saturates
    for (int i = 0; i < 300; i++) begin
      send_frame(8'(i % 4), 8'($urandom_range(0, 255)), 1'b1);
      if (i == 254) check("err_255", bus.ERR_COUNT, 255);
    end
    check("err_sat", bus.ERR_COUNT, 255);
    check("err_sat_cmd", bus.CMD_COUNT, 0);

    // Command counter wraps
    for (int i = 0; i < 256; i++) begin
      send_frame(8'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 1'b0);
      ack_write(0, hi);
      if (i == 254) check("cmd_255", bus.CMD_COUNT, 255);
    end
    check("cmd_wrap", bus.CMD_COUNT, 0);
    check("err_still_sat", bus.ERR_COUNT, 255);

    repeat (3) tick();
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
